// File: rtl/seg_pkg.sv
// Shared types and default constants for the multiplexed digit scanner.
package seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam int DEF_NUM_DIGITS   = 4;
    localparam int DEF_SCAN_DIV     = 12000;
    localparam int DEF_BLANK_CYCLES = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg_scan.sv
// Multiplexed hex-digit scanner with double-buffered display and per-digit dead time.
// Optional leading-zero suppression: define SEG_SCAN_LEADING_ZERO_BLANK_EN.
module seg_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int SCAN_DIV     = DEF_SCAN_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int CW = $clog2(max_int(SCAN_DIV, BLANK_CYCLES));
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int VW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0]         SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE    = NUM_DIGITS'(1);

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [VW-1:0]         shadow, display, display_nxt;
    logic                  pending, pending_nxt;
    logic                  boundary;
    logic [NUM_DIGITS-1:0] en_nxt;
    logic [3:0]            bcd_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        idx_nxt   = idx;
        boundary  = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = SHOW;
                    cnt_nxt   = '0;
                end
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    if (idx == IDX_LAST) begin
                        idx_nxt  = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_nxt  = idx + IW'(1);
                    end
                end
            end
            default: begin
                state_nxt = BLANK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Display only swaps at a frame boundary; a load on that same edge re-arms pending.
    always_comb begin
        display_nxt = (boundary && pending) ? shadow : display;
        pending_nxt = load | (pending & ~boundary);
    end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lit_mask;

    // A digit stays lit if it or any more-significant digit is non-zero.
    always_comb begin
        logic acc;
        acc      = 1'b0;
        lit_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc         = acc | (|display_nxt[4*i +: 4]);
            lit_mask[i] = acc;
        end
        lit_mask[0] = 1'b1;
    end
`endif

    // Outputs are registered from the next state so they track the current state exactly.
    always_comb begin
        en_nxt  = '0;
        bcd_nxt = 4'h0;
        if (state_nxt == SHOW) begin
            bcd_nxt = display_nxt[{idx_nxt, 2'b00} +: 4];
            en_nxt  = DIG_ONE << idx_nxt;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
            en_nxt  = en_nxt & lit_mask;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            shadow     <= '0;
            display    <= '0;
            pending    <= 1'b0;
            digit_en   <= '0;
            bcd_out    <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            if (load) begin
                shadow <= value_in;
            end
            display    <= display_nxt;
            pending    <= pending_nxt;
            digit_en   <= en_nxt;
            bcd_out    <= bcd_nxt;
            frame_done <= boundary;
        end
    end

endmodule
